// File: rtl/compliance_testutil.sv
// -----------------------------------------------------------------------------
// compliance_testutil
// Bus-slave test utility for RV32 compliance runs. Captures the signature
// BEGIN/END pointers and the HALT write from the core. On HALT it walks the
// signature region of data memory through a dedicated read port and streams
// every word out on a valid/ready interface, ending with sig_last.
//
// Optional feature macro: TESTUTIL_TIMEOUT_EN
//   defined   - a watchdog counts cycles spent in RUN. After TIMEOUT_CYC cycles
//               with no HALT it raises timeout and halted and goes straight to
//               DONE without dumping anything.
//   undefined - there is no watchdog, timeout is held at 0 and RUN lasts
//               until HALT.
// -----------------------------------------------------------------------------
module compliance_testutil #(
    parameter logic [29:0] HALT_WADDR  = 30'h2007FFFD,
    parameter int          MEM_AW      = 18,
    parameter int          TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_stb,
    input  logic              bus_we,
    input  logic [29:0]       bus_adr,
    input  logic [31:0]       bus_dat_w,
    output logic              bus_ack,
    output logic              mem_re,
    output logic [MEM_AW-1:0] mem_adr,
    input  logic [31:0]       mem_rdata,
    output logic              sig_valid,
    input  logic              sig_ready,
    output logic [31:0]       sig_data,
    output logic              sig_last,
    output logic              halted,
    output logic              done,
    output logic              timeout
);

    localparam logic [29:0] BEGIN_WADDR = HALT_WADDR - 30'd1;
    localparam logic [29:0] END_WADDR   = HALT_WADDR - 30'd2;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_START = 3'd1,
        ST_FETCH = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EMIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t state_r;
    state_t state_next_s;

    // Address decode of the current bus request
    logic hit_halt_s;
    logic hit_begin_s;
    logic hit_end_s;
    logic hit_any_s;

    // Registered bus request; writes take effect one cycle after the strobe
    logic              bus_ack_r;
    logic              wr_halt_r;
    logic              wr_begin_r;
    logic              wr_end_r;
    logic [MEM_AW-1:0] wdat_idx_r;

    // Signature pointers, stored as dram word indices
    logic [MEM_AW-1:0] begin_idx_r;
    logic [MEM_AW-1:0] end_idx_r;
    logic [MEM_AW-1:0] ptr_r;
    logic [MEM_AW-1:0] lim_r;
    logic [MEM_AW-1:0] ptr_next_s;
    logic [MEM_AW-1:0] ptr_inc_s;

    // Registered outputs
    logic              mem_re_r;
    logic [MEM_AW-1:0] mem_adr_r;
    logic              sig_valid_r;
    logic [31:0]       sig_data_r;
    logic              sig_last_r;
    logic              halted_r;
    logic              done_r;
    logic              timeout_r;

    logic              wdog_fire_s;

    // Only the word-index bits of a pointer matter; the rest is discarded
    logic unused_bits_s;
    assign unused_bits_s = ^{bus_dat_w[31:MEM_AW+2], bus_dat_w[1:0]};

    assign hit_halt_s  = (bus_adr == HALT_WADDR);
    assign hit_begin_s = (bus_adr == BEGIN_WADDR);
    assign hit_end_s   = (bus_adr == END_WADDR);
    assign hit_any_s   = hit_halt_s | hit_begin_s | hit_end_s;

    assign ptr_inc_s = ptr_r + {{(MEM_AW-1){1'b0}}, 1'b1};

`ifdef TESTUTIL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wdog_r;

    // A HALT arriving on the last watchdog cycle still wins over the timeout
    assign wdog_fire_s = (state_r == ST_RUN) && !wr_halt_r &&
                         (wdog_r == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog: counts cycles while the core is still running
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_r <= {WD_W{1'b0}};
        end else if (state_r == ST_RUN) begin
            wdog_r <= wdog_r + {{(WD_W-1){1'b0}}, 1'b1};
        end else begin
            wdog_r <= wdog_r;
        end
    end
`else
    assign wdog_fire_s = 1'b0;
`endif

    // Bus front end: register ack and decoded write strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_ack_r  <= 1'b0;
            wr_halt_r  <= 1'b0;
            wr_begin_r <= 1'b0;
            wr_end_r   <= 1'b0;
            wdat_idx_r <= {MEM_AW{1'b0}};
        end else begin
            bus_ack_r  <= bus_stb && hit_any_s;
            wr_halt_r  <= bus_stb && bus_we && hit_halt_s;
            wr_begin_r <= bus_stb && bus_we && hit_begin_s;
            wr_end_r   <= bus_stb && bus_we && hit_end_s;
            wdat_idx_r <= bus_dat_w[MEM_AW+1:2];
        end
    end

    // BEGIN/END pointer registers, writable only while the core runs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            begin_idx_r <= {MEM_AW{1'b0}};
            end_idx_r   <= {MEM_AW{1'b0}};
        end else if (state_r == ST_RUN) begin
            if (wr_begin_r) begin
                begin_idx_r <= wdat_idx_r;
            end else begin
                begin_idx_r <= begin_idx_r;
            end
            if (wr_end_r) begin
                end_idx_r <= wdat_idx_r;
            end else begin
                end_idx_r <= end_idx_r;
            end
        end else begin
            begin_idx_r <= begin_idx_r;
            end_idx_r   <= end_idx_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and next read pointer
    always_comb begin
        state_next_s = state_r;
        ptr_next_s   = ptr_r;
        case (state_r)
            ST_RUN: begin
                if (wr_halt_r) begin
                    state_next_s = ST_START;
                end else if (wdog_fire_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_START: begin
                // Unsigned compare: an END below BEGIN gives an empty dump
                if (ptr_r >= lim_r) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                state_next_s = ST_EMIT;
            end
            ST_EMIT: begin
                if (sig_ready) begin
                    ptr_next_s = ptr_inc_s;
                    if (sig_last_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end else begin
                    state_next_s = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_next_s = ST_DONE;
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // Dump walk pointer and limit, latched from BEGIN/END at HALT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= {MEM_AW{1'b0}};
            lim_r <= {MEM_AW{1'b0}};
        end else if ((state_r == ST_RUN) && wr_halt_r) begin
            ptr_r <= begin_idx_r;
            lim_r <= end_idx_r;
        end else begin
            ptr_r <= ptr_next_s;
            lim_r <= lim_r;
        end
    end

    // Memory read port: one strobe per FETCH, address from the walk pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_re_r  <= 1'b0;
            mem_adr_r <= {MEM_AW{1'b0}};
        end else if (state_next_s == ST_FETCH) begin
            mem_re_r  <= 1'b1;
            mem_adr_r <= ptr_next_s;
        end else begin
            mem_re_r  <= 1'b0;
            mem_adr_r <= {MEM_AW{1'b0}};
        end
    end

    // Signature stream: load in WAIT, hold through EMIT until accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_valid_r <= 1'b0;
            sig_data_r  <= 32'h0000_0000;
            sig_last_r  <= 1'b0;
        end else if (state_r == ST_WAIT) begin
            sig_valid_r <= 1'b1;
            sig_data_r  <= mem_rdata;
            sig_last_r  <= (ptr_inc_s == lim_r);
        end else if ((state_r == ST_EMIT) && sig_ready) begin
            sig_valid_r <= 1'b0;
            sig_data_r  <= sig_data_r;
            sig_last_r  <= 1'b0;
        end else begin
            sig_valid_r <= sig_valid_r;
            sig_data_r  <= sig_data_r;
            sig_last_r  <= sig_last_r;
        end
    end

    // Sticky status flags: halted on leaving RUN, done on entering DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_r  <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            halted_r  <= halted_r | ((state_r == ST_RUN) && (state_next_s != ST_RUN));
            done_r    <= done_r | (state_next_s == ST_DONE);
            timeout_r <= timeout_r | wdog_fire_s;
        end
    end

    assign bus_ack   = bus_ack_r;
    assign mem_re    = mem_re_r;
    assign mem_adr   = mem_adr_r;
    assign sig_valid = sig_valid_r;
    assign sig_data  = sig_data_r;
    assign sig_last  = sig_last_r;
    assign halted    = halted_r;
    assign done      = done_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_compliance_testutil.sv
// -----------------------------------------------------------------------------
// Bench for compliance_testutil. The bench plays the dram (every word is a
// fixed function of its index) and the signature consumer. Expected dumps are
// the list of dram words between the BEGIN and END word indices.
// -----------------------------------------------------------------------------
module tb_compliance_testutil;

    localparam logic [29:0] HALT_A  = 30'h2007FFFD;
    localparam logic [29:0] BEGIN_A = 30'h2007FFFC;
    localparam logic [29:0] END_A   = 30'h2007FFFB;
`ifdef TESTUTIL_TIMEOUT_EN
    localparam int TO_CYC = 400;
`else
    localparam int TO_CYC = 1000000;
`endif

    logic        clk;
    logic        rst;
    logic        bus_stb;
    logic        bus_we;
    logic [29:0] bus_adr;
    logic [31:0] bus_dat_w;
    logic        bus_ack;
    logic        mem_re;
    logic [17:0] mem_adr;
    logic [31:0] mem_rdata;
    logic        sig_valid;
    logic        sig_ready;
    logic [31:0] sig_data;
    logic        sig_last;
    logic        halted;
    logic        done;
    logic        timeout;

    int tests = 0;
    int fails = 0;

    compliance_testutil #(
        .HALT_WADDR (HALT_A),
        .MEM_AW     (18),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_stb  (bus_stb),
        .bus_we   (bus_we),
        .bus_adr  (bus_adr),
        .bus_dat_w(bus_dat_w),
        .bus_ack  (bus_ack),
        .mem_re   (mem_re),
        .mem_adr  (mem_adr),
        .mem_rdata(mem_rdata),
        .sig_valid(sig_valid),
        .sig_ready(sig_ready),
        .sig_data (sig_data),
        .sig_last (sig_last),
        .halted   (halted),
        .done     (done),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dram contents: unique word per index
    function automatic logic [31:0] memf(input logic [17:0] i);
        return 32'hA500_0000 ^ {14'd0, i} ^ {i[13:0], 18'd0};
    endfunction

    // Dram read port: data valid the cycle after mem_re
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= memf(mem_adr);
        else        mem_rdata <= 32'h0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {7'd0, bus_ack, mem_re, mem_adr, sig_valid, sig_data, sig_last, halted, done, timeout};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        bus_stb = 1'b0;
        bus_we = 1'b0;
        sig_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst = 1'b1;
    endtask

    task automatic bus_op(input logic [29:0] a, input logic we, input logic [31:0] d, input logic exp_ack);
        @(negedge clk);
        bus_stb = 1'b1; bus_we = we; bus_adr = a; bus_dat_w = d;
        @(negedge clk);
        bus_stb = 1'b0; bus_we = 1'b0;
        chk("bus_ack", {63'd0, bus_ack}, {63'd0, exp_ack});
    endtask

    // Consume a dump and compare against the dram words from b to e
    task automatic collect(input logic [31:0] b, input logic [31:0] e, input int stall_idx, input bit chk_lat);
        logic [31:0] expq[$];
        logic [17:0] idxq[$];
        int bi, ei, n, got, cyc, bound, stall_cnt;
        bit pend, first_seen;
        logic [31:0] pd;
        logic pl;
        bi = int'(b[19:2]);
        ei = int'(e[19:2]);
        for (int i = bi; i < ei; i++) begin
            idxq.push_back(18'(i));
            expq.push_back(memf(18'(i)));
        end
        n = expq.size();
        got = 0; cyc = 0; stall_cnt = 0; pend = 0; first_seen = 0; pd = 32'd0; pl = 1'b0;
        bound = 40 + 16 * n + 12;
        while (!done && cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (chk_lat && cyc == 1) chk("halted_at_start", {63'd0, halted}, 64'd1);
            if (pend) begin
                chk("hold_valid", {63'd0, sig_valid}, 64'd1);
                chk("hold_data", {32'd0, sig_data}, {32'd0, pd});
                chk("hold_last", {63'd0, sig_last}, {63'd0, pl});
            end
            if (mem_re) begin
                if (got < n) chk("mem_adr", {46'd0, mem_adr}, {46'd0, idxq[got]});
                else         chk("extra_mem_re", {63'd0, mem_re}, 64'd0);
            end
            if (sig_valid && got >= n) chk("extra_valid", {63'd0, sig_valid}, 64'd0);
            if (sig_valid && chk_lat && !first_seen) begin
                chk("first_valid_latency", 64'(cyc), 64'd4);
                first_seen = 1;
            end
            if (sig_valid && got == stall_idx && stall_cnt < 10) begin
                sig_ready = 1'b0;
                stall_cnt++;
            end else begin
                sig_ready = ($urandom_range(0, 3) != 0);
            end
            if (sig_valid && sig_ready && got < n) begin
                chk("sig_data", {32'd0, sig_data}, {32'd0, expq[got]});
                chk("sig_last", {63'd0, sig_last}, {63'd0, (got == n - 1)});
                got++;
            end
            pend = sig_valid && !sig_ready;
            pd = sig_data;
            pl = sig_last;
        end
        sig_ready = 1'b0;
        chk("dump_count", 64'(got), 64'(n));
        chk("done_after_dump", {63'd0, done}, 64'd1);
        chk("halted_after_dump", {63'd0, halted}, 64'd1);
        chk("timeout_low", {63'd0, timeout}, 64'd0);
        chk("valid_after_done", {63'd0, sig_valid}, 64'd0);
        if (stall_idx >= 0 && stall_idx < n) chk("stall_cycles", 64'(stall_cnt), 64'd10);
        if (n == 0 && chk_lat) chk("empty_done_latency", {63'd0, (cyc <= 3)}, 64'd1);
    endtask

    task automatic run_dump(input logic [31:0] b, input logic [31:0] e, input int stall_idx, input bit chk_lat);
        bus_op(BEGIN_A, 1'b1, b, 1'b1);
        bus_op(END_A, 1'b1, e, 1'b1);
        bus_op(HALT_A, 1'b1, $urandom, 1'b1);
        collect(b, e, stall_idx, chk_lat);
    endtask

    initial begin
        logic [31:0] rb, re;
        rst = 1'b0; bus_stb = 1'b0; bus_we = 1'b0; bus_adr = 30'd0;
        bus_dat_w = 32'd0; sig_ready = 1'b0;
        do_reset();

        // Decode: read hit acked, neighbours of the register block not acked
        bus_op(BEGIN_A, 1'b0, 32'h0, 1'b1);
        bus_op(HALT_A + 30'd1, 1'b1, 32'h1234_5678, 1'b0);
        bus_op(END_A - 30'd1, 1'b1, 32'h1234_5678, 1'b0);
        repeat (3) @(negedge clk);
        chk("no_halt_on_miss", {62'd0, halted, done}, 64'd0);

        // Basic four-word dump with latency check
        run_dump(32'h8000_1000, 32'h8000_1010, -1, 1'b1);

        // Consumer stall on word 2
        do_reset();
        run_dump(32'h8000_1000, 32'h8000_1010, 1, 1'b1);

        // Empty region
        do_reset();
        run_dump(32'h8000_2000, 32'h8000_2000, -1, 1'b1);

        // BEGIN write after HALT must not move the dump range
        do_reset();
        bus_op(BEGIN_A, 1'b1, 32'h8000_1000, 1'b1);
        bus_op(END_A, 1'b1, 32'h8000_1010, 1'b1);
        bus_op(HALT_A, 1'b1, 32'h0, 1'b1);
        bus_op(BEGIN_A, 1'b1, 32'h8000_3000, 1'b1);
        collect(32'h8000_1000, 32'h8000_1010, -1, 1'b0);

        // END index zero with nonzero BEGIN, and END below BEGIN: empty
        do_reset();
        run_dump(32'h8000_0010, 32'h8000_0000, -1, 1'b1);
        do_reset();
        run_dump(32'h8000_1020, 32'h8000_1010, -1, 1'b1);

        // Reset during word 2 of a dump, then a fresh dump
        do_reset();
        bus_op(BEGIN_A, 1'b1, 32'h8000_1000, 1'b1);
        bus_op(END_A, 1'b1, 32'h8000_1010, 1'b1);
        bus_op(HALT_A, 1'b1, 32'h0, 1'b1);
        sig_ready = 1'b0;
        for (int k = 0; k < 20 && !sig_valid; k++) @(negedge clk);
        chk("mid_w1_data", {32'd0, sig_data}, {32'd0, memf(18'h400)});
        sig_ready = 1'b1;
        @(negedge clk);
        sig_ready = 1'b0;
        for (int k = 0; k < 20 && !sig_valid; k++) @(negedge clk);
        chk("mid_w2_data", {32'd0, sig_data}, {32'd0, memf(18'h401)});
        #2 rst = 1'b0;
        #1 chk("reset_mid_dump", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_dump(32'h8000_1000, 32'h8000_1008, -1, 1'b1);

        // Randomized regions and consumer back-pressure
        for (int t = 0; t < 8; t++) begin
            do_reset();
            rb = 32'h8000_0000 | (32'($urandom_range(0, 262143)) << 2);
            re = rb + 32'($urandom_range(0, 6)) * 32'd4;
            run_dump(rb, re, int'($urandom_range(0, 5)), 1'b1);
        end

`ifdef TESTUTIL_TIMEOUT_EN
        // Watchdog: no HALT ever written
        begin
            int c;
            bit saw_valid;
            do_reset();
            c = 0;
            saw_valid = 0;
            while (!timeout && c < TO_CYC + 20) begin
                @(negedge clk);
                c++;
                if (sig_valid) saw_valid = 1;
            end
            chk("timeout_cycle", 64'(c), 64'(TO_CYC));
            chk("timeout_flags", {61'd0, timeout, halted, done}, 64'd7);
            repeat (5) @(negedge clk);
            chk("timeout_no_valid", {63'd0, saw_valid | sig_valid}, 64'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
